// File: rtl/game_ctrl_fsm.sv
// game_ctrl_fsm - top-level sequencer for the bomb-dismantlement game.
//
// Runs the game through an explicit state machine. It drives enables for
// the bomb matrix, code display, countdown timer and code input/verify
// blocks, and issues reset pulses to those blocks. It also holds the round
// counter and the LFSR code generator, detects start-button edges, and can
// re-arm itself after a win or loss.
//
// Ports
//   i_clk         system clock
//   i_rst_n       synchronous active-low reset
//   i_enable      master game switch (level)
//   i_start_btn   debounced start button (level)
//   i_fail        defuse failed, from timer/verify (level)
//   i_success     code correct, from verify (level)
//   o_random      code for the current round
//   o_bomb_en     bomb matrix display enable
//   o_show_en     code display enable
//   o_timer_en    countdown timer enable
//   o_input_en    code input/verify enable
//   o_sub_rst_n   sub-block reset, active-low
//   o_sub_rst_p   sub-block reset, active-high (complement of o_sub_rst_n)
//   o_round       rounds completed in this game
//   o_win         high in WIN
//   o_lose        high in LOSE
//
// state    | meaning
// ---------+---------------------------------------------------------------
// OFF      | game switched off, all enables low
// INIT     | sub-block reset held for RST_PULSE cycles, round cleared
// IDLE     | bomb shown, waiting for a start press
// SHOW     | code displayed for SHOW_CYCLES cycles
// ARM      | timer running, player entering the code
// WIN      | all rounds defused
// LOSE     | defuse failed
// SHUTDOWN | switch dropped, sub-block reset held for RST_PULSE, then OFF
//
// All outputs are registered from the next-state decode. Enables therefore
// change on the same edge as the state register.

module game_ctrl_fsm #(
   parameter int          RAND_W         = 5,
   parameter logic [15:0] LFSR_SEED      = 16'hACE1,
   parameter int          RST_PULSE      = 2,
   parameter int          SHOW_CYCLES    = 50000000,
   parameter int          ROUNDS         = 3,
   parameter bit          AUTO_RESTART   = 1'b1,
   parameter int          RESTART_CYCLES = 100000000
) (
   input  logic                            i_clk,
   input  logic                            i_rst_n,
   input  logic                            i_enable,
   input  logic                            i_start_btn,
   input  logic                            i_fail,
   input  logic                            i_success,
   output logic [RAND_W-1:0]               o_random,
   output logic                            o_bomb_en,
   output logic                            o_show_en,
   output logic                            o_timer_en,
   output logic                            o_input_en,
   output logic                            o_sub_rst_n,
   output logic                            o_sub_rst_p,
   output logic [$clog2(ROUNDS+1)-1:0]     o_round,
   output logic                            o_win,
   output logic                            o_lose
);

   localparam int RND_W   = $clog2(ROUNDS + 1);
   localparam int MAX_A   = (RST_PULSE > SHOW_CYCLES) ? RST_PULSE : SHOW_CYCLES;
   localparam int MAX_CNT = (MAX_A > RESTART_CYCLES) ? MAX_A : RESTART_CYCLES;
   localparam int CNT_W   = (MAX_CNT > 1) ? $clog2(MAX_CNT) : 1;

   // The counter is loaded with duration-1 and the state exits on the
   // cycle it reads zero, so each timed state lasts exactly its duration.
   localparam logic [CNT_W-1:0] LD_RST     = CNT_W'(RST_PULSE - 1);
   localparam logic [CNT_W-1:0] LD_SHOW    = CNT_W'(SHOW_CYCLES - 1);
   localparam logic [CNT_W-1:0] LD_RESTART = CNT_W'(RESTART_CYCLES - 1);
   localparam logic [RND_W-1:0] ROUNDS_L   = RND_W'(ROUNDS);

   typedef enum logic [2:0] {
      S_OFF,
      S_INIT,
      S_IDLE,
      S_SHOW,
      S_ARM,
      S_WIN,
      S_LOSE,
      S_SHUTDOWN
   } state_t;

   state_t            r_state;
   state_t            w_next;
   logic [CNT_W-1:0]  r_cnt;
   logic [CNT_W-1:0]  w_cnt_next;
   logic              w_cnt_done;
   logic [15:0]       r_lfsr;
   logic [15:0]       w_lfsr_next;
   logic              r_start_q;
   logic              w_start_rise;
   logic [RAND_W-1:0] r_random;
   logic [RAND_W-1:0] w_random_next;
   logic [RND_W-1:0]  r_round;
   logic [RND_W-1:0]  w_round_next;
   logic [RND_W-1:0]  w_round_inc;
   logic              w_arm_pulse;

   logic              r_bomb_en;
   logic              r_show_en;
   logic              r_timer_en;
   logic              r_input_en;
   logic              r_sub_rst_n;
   logic              r_win;
   logic              r_lose;

   assign w_start_rise = i_start_btn & ~r_start_q;
   assign w_cnt_done   = (r_cnt == '0);
   assign w_round_inc  = r_round + RND_W'(1);

   // Galois LFSR, x^16 + x^14 + x^13 + x^11.
   assign w_lfsr_next = r_lfsr[0] ? ({1'b0, r_lfsr[15:1]} ^ 16'hB400)
                                  :  {1'b0, r_lfsr[15:1]};

   always_comb begin
      w_next        = r_state;
      w_cnt_next    = w_cnt_done ? r_cnt : r_cnt - CNT_W'(1);
      w_random_next = r_random;
      w_round_next  = r_round;
      w_arm_pulse   = 1'b0;

      case (r_state)
         S_OFF: begin
            if (i_enable) w_next = S_INIT;
         end
         S_INIT: begin
            if (w_cnt_done) w_next = S_IDLE;
         end
         S_IDLE: begin
            if (w_start_rise) begin
               w_next        = S_SHOW;
               w_random_next = r_lfsr[RAND_W-1:0];
            end
         end
         S_SHOW: begin
            if (w_cnt_done) w_next = S_ARM;
         end
         S_ARM: begin
            if (i_fail) begin
               w_next = S_LOSE;
            end else if (i_success) begin
               w_round_next = w_round_inc;
               if (w_round_inc == ROUNDS_L) begin
                  w_next = S_WIN;
               end else begin
                  w_next        = S_SHOW;
                  w_random_next = r_lfsr[RAND_W-1:0];
                  w_arm_pulse   = 1'b1;
               end
            end
         end
         S_WIN, S_LOSE: begin
            if (AUTO_RESTART) begin
               if (w_cnt_done) w_next = S_INIT;
            end else begin
               if (w_start_rise) w_next = S_INIT;
            end
         end
         S_SHUTDOWN: begin
            if (w_cnt_done) w_next = S_OFF;
         end
         default: w_next = S_OFF;
      endcase

      // Dropping the master switch overrides any transition in flight.
      if (!i_enable && (r_state != S_OFF) && (r_state != S_SHUTDOWN)) begin
         w_next        = S_SHUTDOWN;
         w_random_next = r_random;
         w_round_next  = r_round;
         w_arm_pulse   = 1'b0;
      end

      if (w_next != r_state) begin
         case (w_next)
            S_INIT: begin
               w_cnt_next   = LD_RST;
               w_round_next = '0;
            end
            S_SHUTDOWN:   w_cnt_next = LD_RST;
            S_SHOW:       w_cnt_next = LD_SHOW;
            S_WIN,S_LOSE: w_cnt_next = LD_RESTART;
            default:      w_cnt_next = '0;
         endcase
      end
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_state     <= S_OFF;
         r_cnt       <= '0;
         r_lfsr      <= LFSR_SEED;
         r_start_q   <= 1'b0;
         r_random    <= '0;
         r_round     <= '0;
         r_bomb_en   <= 1'b0;
         r_show_en   <= 1'b0;
         r_timer_en  <= 1'b0;
         r_input_en  <= 1'b0;
         r_sub_rst_n <= 1'b1;
         r_win       <= 1'b0;
         r_lose      <= 1'b0;
      end else begin
         r_state     <= w_next;
         r_cnt       <= w_cnt_next;
         r_start_q   <= i_start_btn;
         r_random    <= w_random_next;
         r_round     <= w_round_next;
         if (i_enable) r_lfsr <= w_lfsr_next;
         r_bomb_en   <= (w_next == S_IDLE) || (w_next == S_SHOW) || (w_next == S_ARM);
         r_show_en   <= (w_next == S_SHOW);
         r_timer_en  <= (w_next == S_ARM);
         r_input_en  <= (w_next == S_ARM);
         // ARM->SHOW issues a one-cycle reset to clear timer and input blocks.
         r_sub_rst_n <= !((w_next == S_INIT) || (w_next == S_SHUTDOWN) || w_arm_pulse);
         r_win       <= (w_next == S_WIN);
         r_lose      <= (w_next == S_LOSE);
      end
   end

   assign o_random    = r_random;
   assign o_round     = r_round;
   assign o_bomb_en   = r_bomb_en;
   assign o_show_en   = r_show_en;
   assign o_timer_en  = r_timer_en;
   assign o_input_en  = r_input_en;
   assign o_sub_rst_n = r_sub_rst_n;
   assign o_sub_rst_p = ~r_sub_rst_n;
   assign o_win       = r_win;
   assign o_lose      = r_lose;

endmodule

// File: tb/tb_game_ctrl_fsm.sv
// Testbench for game_ctrl_fsm with small timing parameters. Two instances
// share all inputs: one re-arms automatically, the other waits for a start
// press after WIN/LOSE.

module tb_game_ctrl_fsm;

   localparam int RAND_W = 5;
   localparam int RW     = 2;

   logic clk = 1'b0;
   logic rst_n = 1'b0, enable = 1'b0, start_btn = 1'b0, fail = 1'b0, success = 1'b0;

   logic [RAND_W-1:0] a_random, b_random;
   logic a_bomb, a_show, a_timer, a_input, a_sub_n, a_sub_p, a_win, a_lose;
   logic b_bomb, b_show, b_timer, b_input, b_sub_n, b_sub_p, b_win, b_lose;
   logic [RW-1:0] a_round, b_round;

   always #5 clk = ~clk;

   game_ctrl_fsm #(
      .RAND_W(RAND_W), .LFSR_SEED(16'hACE1), .RST_PULSE(2), .SHOW_CYCLES(4),
      .ROUNDS(2), .AUTO_RESTART(1'b1), .RESTART_CYCLES(3)
   ) u_dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_enable(enable), .i_start_btn(start_btn),
      .i_fail(fail), .i_success(success), .o_random(a_random),
      .o_bomb_en(a_bomb), .o_show_en(a_show), .o_timer_en(a_timer),
      .o_input_en(a_input), .o_sub_rst_n(a_sub_n), .o_sub_rst_p(a_sub_p),
      .o_round(a_round), .o_win(a_win), .o_lose(a_lose)
   );

   game_ctrl_fsm #(
      .RAND_W(RAND_W), .LFSR_SEED(16'hACE1), .RST_PULSE(2), .SHOW_CYCLES(4),
      .ROUNDS(2), .AUTO_RESTART(1'b0), .RESTART_CYCLES(3)
   ) u_dut_nr (
      .i_clk(clk), .i_rst_n(rst_n), .i_enable(enable), .i_start_btn(start_btn),
      .i_fail(fail), .i_success(success), .o_random(b_random),
      .o_bomb_en(b_bomb), .o_show_en(b_show), .o_timer_en(b_timer),
      .o_input_en(b_input), .o_sub_rst_n(b_sub_n), .o_sub_rst_p(b_sub_p),
      .o_round(b_round), .o_win(b_win), .o_lose(b_lose)
   );

   // Packed view: {bomb, show, timer, input, sub_rst_n, win, lose, round[1:0]}
   logic [8:0] pa, pb;
   assign pa = {a_bomb, a_show, a_timer, a_input, a_sub_n, a_win, a_lose, a_round};
   assign pb = {b_bomb, b_show, b_timer, b_input, b_sub_n, b_win, b_lose, b_round};

   localparam logic [8:0] E_OFF     = 9'b0000_1_0_0_00;
   localparam logic [8:0] E_INIT    = 9'b0000_0_0_0_00;
   localparam logic [8:0] E_IDLE    = 9'b1000_1_0_0_00;
   localparam logic [8:0] E_SHOW0   = 9'b1100_1_0_0_00;
   localparam logic [8:0] E_ARM0    = 9'b1011_1_0_0_00;
   localparam logic [8:0] E_SHOWP1  = 9'b1100_0_0_0_01;
   localparam logic [8:0] E_SHOW1   = 9'b1100_1_0_0_01;
   localparam logic [8:0] E_ARM1    = 9'b1011_1_0_0_01;
   localparam logic [8:0] E_WIN2    = 9'b0000_1_1_0_10;
   localparam logic [8:0] E_LOSE1   = 9'b0000_1_0_1_01;
   localparam logic [8:0] E_SD1     = 9'b0000_0_0_0_01;
   localparam logic [8:0] E_OFF1    = 9'b0000_1_0_0_01;

   // Reference LFSR: Galois, x^16+x^14+x^13+x^11, seed ACE1.
   logic [15:0] m_lfsr;
   function automatic logic [15:0] lfsr_step(input logic [15:0] s);
      return s[0] ? ((s >> 1) ^ 16'hB400) : (s >> 1);
   endfunction
   always @(posedge clk) begin
      if (!rst_n)      m_lfsr <= 16'hACE1;
      else if (enable) m_lfsr <= lfsr_step(m_lfsr);
   end

   int n_pass = 0;
   int n_total = 0;
   logic [RAND_W-1:0] exp_rnd;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic ticks(input int n);
      for (int k = 0; k < n; k++) tick();
   endtask

   task automatic chk(input string name, input logic [8:0] act, input logic actp,
                      input logic [8:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: outputs got %b expected %b", name, act, exp);
      n_total++;
      if (actp === ~exp[4]) n_pass++;
      else $display("FAIL %s sub_rst_p: got %b expected %b", name, actp, ~exp[4]);
   endtask

   task automatic chk_rnd(input string name, input logic [RAND_W-1:0] act,
                          input logic [RAND_W-1:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s random: got %h expected %h", name, act, exp);
   endtask

   task automatic drive(input logic r, input logic e, input logic s,
                        input logic f, input logic c);
      rst_n = r; enable = e; start_btn = s; fail = f; success = c;
   endtask

   typedef struct {
      logic       rst_n, en, start, fail, succ, cap;
      logic [8:0] exp;
   } vec_t;

   function automatic vec_t mkv(input logic r, input logic e, input logic s,
                                input logic f, input logic c, input logic cap,
                                input logic [8:0] exp);
      vec_t v;
      v.rst_n = r; v.en = e; v.start = s; v.fail = f; v.succ = c; v.cap = cap;
      v.exp = exp;
      return v;
   endfunction

   vec_t vecs[30];

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      // Power-up, held start button, two-round win with auto re-arm.
      vecs[0]  = mkv(0,0,0,0,0,0, E_OFF);
      vecs[1]  = mkv(0,0,0,0,0,0, E_OFF);
      vecs[2]  = mkv(0,0,0,0,0,0, E_OFF);
      vecs[3]  = mkv(1,0,0,0,0,0, E_OFF);
      vecs[4]  = mkv(1,1,0,0,0,0, E_INIT);
      vecs[5]  = mkv(1,1,0,0,0,0, E_INIT);
      vecs[6]  = mkv(1,1,0,0,0,0, E_IDLE);
      vecs[7]  = mkv(1,1,0,1,1,0, E_IDLE);
      vecs[8]  = mkv(1,1,1,0,0,1, E_SHOW0);
      vecs[9]  = mkv(1,1,1,0,0,0, E_SHOW0);
      vecs[10] = mkv(1,1,1,0,0,0, E_SHOW0);
      vecs[11] = mkv(1,1,1,0,0,0, E_SHOW0);
      vecs[12] = mkv(1,1,1,0,0,0, E_ARM0);
      vecs[13] = mkv(1,1,1,0,0,0, E_ARM0);
      vecs[14] = mkv(1,1,1,0,0,0, E_ARM0);
      vecs[15] = mkv(1,1,1,0,0,0, E_ARM0);
      vecs[16] = mkv(1,1,1,0,0,0, E_ARM0);
      vecs[17] = mkv(1,1,1,0,0,0, E_ARM0);
      vecs[18] = mkv(1,1,0,0,0,0, E_ARM0);
      vecs[19] = mkv(1,1,0,0,1,1, E_SHOWP1);
      vecs[20] = mkv(1,1,0,0,0,0, E_SHOW1);
      vecs[21] = mkv(1,1,0,0,0,0, E_SHOW1);
      vecs[22] = mkv(1,1,0,0,0,0, E_SHOW1);
      vecs[23] = mkv(1,1,0,0,0,0, E_ARM1);
      vecs[24] = mkv(1,1,0,0,1,0, E_WIN2);
      vecs[25] = mkv(1,1,0,0,0,0, E_WIN2);
      vecs[26] = mkv(1,1,0,0,0,0, E_WIN2);
      vecs[27] = mkv(1,1,0,0,0,0, E_INIT);
      vecs[28] = mkv(1,1,0,0,0,0, E_INIT);
      vecs[29] = mkv(1,1,0,0,0,0, E_IDLE);

      exp_rnd = '0;
      for (int i = 0; i < 30; i++) begin
         drive(vecs[i].rst_n, vecs[i].en, vecs[i].start, vecs[i].fail, vecs[i].succ);
         if (!vecs[i].rst_n) exp_rnd = '0;
         if (vecs[i].cap) exp_rnd = m_lfsr[RAND_W-1:0];
         tick();
         chk($sformatf("vec%0d", i), pa, a_sub_p, vecs[i].exp);
         chk_rnd($sformatf("vec%0d", i), a_random, exp_rnd);
      end

      // Simultaneous fail+success in ARM -> LOSE; only the auto instance re-arms.
      drive(0,0,0,0,0); ticks(2);
      drive(1,1,0,0,0); ticks(3);
      drive(1,1,1,0,0); tick();
      drive(1,1,0,0,0); ticks(4);
      chk("lose_arm0_a", pa, a_sub_p, E_ARM0);
      chk("lose_arm0_b", pb, b_sub_p, E_ARM0);
      drive(1,1,0,0,1); exp_rnd = m_lfsr[RAND_W-1:0]; tick();
      drive(1,1,0,0,0); ticks(4);
      chk("lose_arm1_b", pb, b_sub_p, E_ARM1);
      drive(1,1,0,1,1); tick();
      chk("lose_entry_a", pa, a_sub_p, E_LOSE1);
      chk("lose_entry_b", pb, b_sub_p, E_LOSE1);
      chk_rnd("lose_hold_b", b_random, exp_rnd);
      drive(1,1,0,0,0); ticks(3);
      chk("lose_auto_init", pa, a_sub_p, E_INIT);
      chk("lose_noauto_hold", pb, b_sub_p, E_LOSE1);
      ticks(4);
      chk("lose_noauto_wait", pb, b_sub_p, E_LOSE1);
      drive(1,1,1,0,0); tick();
      chk("lose_noauto_restart", pb, b_sub_p, E_INIT);
      ticks(3);
      chk("lose_noauto_idle", pb, b_sub_p, E_IDLE);
      drive(1,1,0,0,0);

      // Shutdown in the second SHOW, re-enable, then reset mid-ARM.
      drive(0,0,0,0,0); ticks(2);
      drive(1,1,0,0,0); ticks(3);
      drive(1,1,1,0,0); tick();
      drive(1,1,0,0,0); ticks(4);
      drive(1,1,0,0,1); exp_rnd = m_lfsr[RAND_W-1:0]; tick();
      drive(1,1,0,0,0); tick();
      chk("sd_show1", pa, a_sub_p, E_SHOW1);
      drive(1,0,0,0,0); tick();
      chk("sd_entry", pa, a_sub_p, E_SD1);
      tick();
      chk("sd_pulse2", pa, a_sub_p, E_SD1);
      tick();
      chk("sd_off", pa, a_sub_p, E_OFF1);
      chk_rnd("sd_hold", a_random, exp_rnd);
      tick();
      chk("sd_off_stay", pa, a_sub_p, E_OFF1);
      drive(1,1,0,0,0); tick();
      chk("sd_reinit", pa, a_sub_p, E_INIT);
      ticks(2);
      chk("sd_idle", pa, a_sub_p, E_IDLE);
      drive(1,1,1,0,0); exp_rnd = m_lfsr[RAND_W-1:0]; tick();
      chk_rnd("sd_new_code", a_random, exp_rnd);
      drive(1,1,0,0,0); ticks(4);
      chk("rst_arm", pa, a_sub_p, E_ARM0);
      drive(0,1,0,0,0); tick();
      chk("rst_mid_arm", pa, a_sub_p, E_OFF);
      chk_rnd("rst_mid_arm", a_random, '0);
      drive(1,1,0,0,0); ticks(3);
      chk("rst_idle", pa, a_sub_p, E_IDLE);
      drive(1,1,1,0,0); exp_rnd = m_lfsr[RAND_W-1:0]; tick();
      chk_rnd("rst_seed_code", a_random, exp_rnd);
      chk("rst_show", pa, a_sub_p, E_SHOW0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/game_ctrl_fsm.md
Name: game_ctrl_fsm

Overview:
- Top-level game sequencer for the bomb-dismantlement game.
- Replaces the flat single-`always` control with an explicit state machine.
- Drives enables for the bomb matrix, code display, countdown timer and code-input/verify blocks, plus reset pulses to all of them.
- Adds multi-round play, an LFSR code generator, button edge detection and a configurable auto-restart.

Parameters:
- RAND_W, 5, width of the generated code; legal range 1..16.
- LFSR_SEED, 16'hACE1, LFSR reset value; must be nonzero.
- RST_PULSE, 2, cycles that sub-block reset is held asserted; ≥1.
- SHOW_CYCLES, 50000000, cycles the code is displayed per round; ≥1.
- ROUNDS, 3, successful rounds needed to win; ≥1.
- AUTO_RESTART, 1, 1 = re-arm automatically after WIN/LOSE; 0 = wait for start press.
- RESTART_CYCLES, 100000000, WIN/LOSE hold time before auto re-arm; ≥1.

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset
- enable  in  1  master game switch (level)
- start_btn  in  1  start button, already debounced, level
- fail  in  1  from timer/verify: defuse failed (level)
- success  in  1  from verify: code correct (level)
- random  out  RAND_W  current round's code
- bomb_en  out  1  bomb matrix display enable
- show_en  out  1  code display enable
- timer_en  out  1  countdown timer enable
- input_en  out  1  code input/verify enable
- sub_rst_n  out  1  sub-block reset, active-low
- sub_rst_p  out  1  sub-block reset, active-high; always the complement of sub_rst_n
- round  out  $clog2(ROUNDS+1)  completed rounds this game
- win  out  1  high in WIN
- lose  out  1  high in LOSE

Behaviour:
- Reset (rst_n=0 at clk edge):
  - state=OFF, random=0, round=0.
  - All enables 0, win=lose=0.
  - sub_rst_n=1, sub_rst_p=0.
  - lfsr=LFSR_SEED, start_btn history register=0.
- All outputs are registered. State-dependent outputs are valid the cycle after the state is entered.
- LFSR:
  - 16-bit Galois, taps x^16+x^14+x^13+x^11.
  - Advances every cycle while enable=1; holds while enable=0.
- Start edge: start_rise = start_btn & ~start_btn_q. A held button generates exactly one event.
- States:
  - OFF: all enables 0. enable=1 → INIT.
  - INIT: sub_rst_n=0 for RST_PULSE cycles; round←0; win=lose=0. Then → IDLE.
  - IDLE: bomb_en=1. start_rise → SHOW, and random←lfsr[RAND_W-1:0] in the same edge.
  - SHOW: bomb_en=1, show_en=1 for exactly SHOW_CYCLES cycles, then → ARM.
  - ARM: bomb_en=1, timer_en=1, input_en=1, show_en=0.
    - fail=1 → LOSE.
    - else success=1: round←round+1.
    - If round+1==ROUNDS → WIN.
    - Otherwise → SHOW with random←new LFSR sample, and a one-cycle sub_rst_n=0 pulse to the timer/input blocks on entry.
    - fail and success in the same cycle: fail wins.
  - WIN / LOSE:
    - All enables 0; win or lose=1 respectively; random and round hold.
    - AUTO_RESTART=1: after RESTART_CYCLES → INIT.
    - AUTO_RESTART=0: start_rise → INIT.
- SHUTDOWN: enable=0 in any state other than OFF/SHUTDOWN → SHUTDOWN next edge.
  - Enables drop to 0 in that same cycle (combinational gating by enable is not allowed; take the one-cycle registered latency).
  - sub_rst_n=0 for RST_PULSE cycles, then → OFF.
  - enable reasserted during SHUTDOWN: complete the pulse, go to OFF, then INIT next cycle.
- fail/success are ignored outside ARM.
- start_rise is ignored outside IDLE and non-auto WIN/LOSE.
- One shared down-counter serves RST_PULSE, SHOW_CYCLES and RESTART_CYCLES. Its width is $clog2 of the largest of these. It is reloaded on every state entry.
- Synchronous reset mid-game overrides everything and returns to OFF with reset values. No sub_rst pulse is issued.

Test Plan:
- Use small parameters: RST_PULSE=2, SHOW_CYCLES=4, ROUNDS=2, RESTART_CYCLES=3.
- Power-up: rst_n=0 for 3 cycles, then enable=1 → OFF, INIT with sub_rst_n=0 for exactly 2 cycles, then IDLE with bomb_en=1; show_en=timer_en=input_en=0.
- Start edge: hold start_btn high 10 cycles in IDLE → exactly one SHOW entry; random equals lfsr[4:0] at the press edge; show_en high exactly 4 cycles, then timer_en=input_en=1.
- Two-round win: success pulse in ARM → round=1, new random, one-cycle sub_rst_n=0, show_en 4 cycles. Second success → WIN, win=1, all enables 0. After 3 cycles → INIT, round=0.
- Simultaneous fail=1 and success=1 in ARM → LOSE, lose=1, round unchanged. With AUTO_RESTART=0: stays in LOSE until start_rise.
- Shutdown mid-SHOW: drop enable → next cycle all enables 0, sub_rst_n=0 for 2 cycles, state OFF. Re-enable → INIT, round=0.
- Reset mid-ARM: rst_n=0 one cycle → all outputs at reset values next edge, lfsr=16'hACE1.
